// File: rtl/if_fetch_buffer.sv
// ---------------------------------------------------------------------------
// if_fetch_buffer
//
// Instruction-fetch front end. Issues sequential fetches to instruction
// memory with up to MAX_INFLIGHT requests outstanding. Responses arrive in
// order and are queued with their PC in a DEPTH-entry FIFO. The FIFO head is
// handed to decode with a valid/ready handshake. A redirect flushes the FIFO,
// restarts fetching at redirect_pc and discards every response still in
// flight.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   redirect_valid/pc taken branch/jump: flush and refetch from redirect_pc
//   imem_req_*        fetch request (valid/ready) and fetch address
//   imem_rsp_*        in-order instruction word returned by memory
//   id_valid/ready    decode handshake for the FIFO head
//   id_pc/npc/ir      head PC, PC+4 and instruction word (0/0/NOOP if empty)
//   occupancy         number of valid FIFO entries
// ---------------------------------------------------------------------------
module if_fetch_buffer #(
    parameter int              XLEN         = 32,
    parameter int              DEPTH        = 4,
    parameter int              MAX_INFLIGHT = 2,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter logic [31:0]     NOOP         = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       imem_req_valid,
    output logic [XLEN-1:0]            imem_req_addr,
    input  logic                       imem_req_ready,
    input  logic                       imem_rsp_valid,
    input  logic [31:0]                imem_rsp_data,
    output logic                       id_valid,
    output logic [XLEN-1:0]            id_pc,
    output logic [XLEN-1:0]            id_npc,
    output logic [31:0]                id_ir,
    input  logic                       id_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic [XLEN-1:0] pc_mem_q [DEPTH];
    logic [31:0]     ir_mem_q [DEPTH];

    logic            credit_ok;
    logic            rsp_ok;
    logic            req_fire;
    logic            push;
    logic            pop;

    // Credit check: reserving a FIFO slot per outstanding request guarantees
    // every response can be written without back-pressure on memory.
    assign credit_ok = (({1'b0, count_q} + {1'b0, inflight_q}) < (CW+1)'(DEPTH))
                       && (inflight_q < CW'(MAX_INFLIGHT));

    assign imem_req_valid = !rst && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_ok = imem_rsp_valid && (inflight_q != '0);
    // Responses belonging to a flushed stream (drop_q > 0) or arriving in the
    // redirect cycle itself never reach the FIFO.
    assign push   = rsp_ok && (drop_q == '0) && !redirect_valid;

    assign id_valid  = (count_q != '0) && !redirect_valid;
    assign pop       = id_valid && id_ready;
    assign id_pc     = (count_q != '0) ? pc_mem_q[head_q] : '0;
    assign id_npc    = (count_q != '0) ? pc_mem_q[head_q] + XLEN'(4) : '0;
    assign id_ir     = (count_q != '0) ? ir_mem_q[head_q] : NOOP;
    assign occupancy = count_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            // Everything still outstanding after this cycle is stale.
            count_d    = '0;
            head_d     = tail_q;
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            inflight_d = inflight_q - CW'(rsp_ok);
            drop_d     = inflight_q - CW'(rsp_ok);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_ok);
            if (rsp_ok && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (push) begin
                tail_d    = tail_q + PW'(1);
                resp_pc_d = resp_pc_q + XLEN'(4);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    // Storage entries carry no reset: count_q alone defines which are valid.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (!rst && push && (tail_q == PW'(gi))) begin
                    pc_mem_q[gi] <= resp_pc_q;
                    ir_mem_q[gi] <= imem_rsp_data;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_if_fetch_buffer.sv
module tb_if_fetch_buffer;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam int          MAXI     = 2;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOOP     = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_npc;
    logic [31:0] id_ir;
    logic        id_ready;
    logic [2:0]  occupancy;

    always #5 clk = ~clk;

    if_fetch_buffer #(
        .XLEN(XLEN), .DEPTH(DEPTH), .MAX_INFLIGHT(MAXI),
        .RESET_PC(RESET_PC), .NOOP(NOOP)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .id_valid(id_valid), .id_pc(id_pc), .id_npc(id_npc), .id_ir(id_ir),
        .id_ready(id_ready), .occupancy(occupancy)
    );

    // Reference model: memory holds accepted requests in order, each tagged
    // stale once a redirect overtakes it; the FIFO is a queue of {pc, ir}.
    typedef struct { logic [31:0] addr; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] ir; } ent_t;
    typedef struct {
        logic r, rd; logic [31:0] rp; logic rdy, idr;
        logic e_req; logic [31:0] e_addr; logic e_idv; logic [31:0] e_pc; int e_occ;
    } vec_t;

    req_t        mem_q[$];
    bit          stale_q[$];
    ent_t        fifo_m[$];
    logic [31:0] m_fetch = RESET_PC;
    int          cyc = 0;
    int          rsp_pct = 100;
    int          lat_lo = 1, lat_hi = 1;
    int          n_chk = 0, n_pass = 0;
    logic        dut_fire;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
    endfunction

    function automatic bit rsp_due();
        return (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Drive one cycle of inputs (at the falling edge), check outputs, then
    // advance the model to the state after the coming rising edge.
    task automatic apply(input logic r, input logic rd, input logic [31:0] rp,
                         input logic rdy, input logic idr, input bit do_chk);
        bit   rv, exp_req, exp_idv, st;
        req_t fr;
        ent_t e;
        rv = !r && rsp_due() && ($urandom_range(99) < rsp_pct);
        rst = r; redirect_valid = rd; redirect_pc = rp;
        imem_req_ready = rdy; id_ready = idr;
        imem_rsp_valid = rv;
        imem_rsp_data  = rv ? data_of(mem_q[0].addr) : $urandom;
        #1;
        dut_fire = imem_req_valid & imem_req_ready;
        exp_req = !r && !rd && (fifo_m.size() + mem_q.size() < DEPTH) && (mem_q.size() < MAXI);
        exp_idv = (fifo_m.size() > 0) && !rd;
        if (do_chk) begin
            chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
            if (!r) begin
                chk("req_addr", imem_req_addr, m_fetch);
                chk("id_valid", 32'(id_valid), 32'(exp_idv));
                chk("occupancy", 32'(occupancy), 32'(fifo_m.size()));
                if (exp_idv) begin
                    chk("id_pc", id_pc, fifo_m[0].pc);
                    chk("id_npc", id_npc, fifo_m[0].pc + 32'd4);
                    chk("id_ir", id_ir, fifo_m[0].ir);
                end else if (fifo_m.size() == 0) begin
                    chk("id_pc_empty", id_pc, 32'h0);
                    chk("id_npc_empty", id_npc, 32'h0);
                    chk("id_ir_empty", id_ir, NOOP);
                end
            end
        end
        if (r) begin
            mem_q.delete(); stale_q.delete(); fifo_m.delete();
            m_fetch = RESET_PC;
        end else begin
            st = 1'b1;
            if (rv) begin
                fr = mem_q.pop_front();
                st = stale_q.pop_front();
            end
            if (exp_idv && idr) void'(fifo_m.pop_front());
            if (rv && !st && !rd) begin
                e.pc = fr.addr; e.ir = data_of(fr.addr);
                fifo_m.push_back(e);
            end
            if (rd) begin
                fifo_m.delete();
                foreach (stale_q[i]) stale_q[i] = 1'b1;
                m_fetch = rp;
            end
            if (exp_req && rdy) begin
                fr.addr = m_fetch;
                fr.due  = cyc + int'($urandom_range(lat_hi, lat_lo));
                mem_q.push_back(fr);
                stale_q.push_back(1'b0);
                m_fetch = m_fetch + 32'd4;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        apply(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        tick();
    endtask

    vec_t tbl[16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int   fires;
        bit   found;
        logic [31:0] first_pc;

        // Table: reset, fill with id_ready=0 (4 requests only), drain, redirect.
        tbl[0]  = '{1,0,0,1,0, 0,32'h0,  0,32'h0,  0};
        tbl[1]  = '{0,0,0,1,0, 1,32'h0,  0,32'h0,  0};
        tbl[2]  = '{0,0,0,1,0, 1,32'h4,  0,32'h0,  0};
        tbl[3]  = '{0,0,0,1,0, 1,32'h8,  1,32'h0,  1};
        tbl[4]  = '{0,0,0,1,0, 1,32'hC,  1,32'h0,  2};
        tbl[5]  = '{0,0,0,1,0, 0,32'h10, 1,32'h0,  3};
        tbl[6]  = '{0,0,0,1,0, 0,32'h10, 1,32'h0,  4};
        tbl[7]  = '{0,0,0,1,1, 0,32'h10, 1,32'h0,  4};
        tbl[8]  = '{0,0,0,1,1, 1,32'h10, 1,32'h4,  3};
        tbl[9]  = '{0,0,0,1,1, 1,32'h14, 1,32'h8,  2};
        tbl[10] = '{0,0,0,1,1, 1,32'h18, 1,32'hC,  2};
        tbl[11] = '{0,0,0,1,1, 1,32'h1C, 1,32'h10, 2};
        tbl[12] = '{0,1,32'h100,1,1, 0,32'h20, 0,32'h0, 2};
        tbl[13] = '{0,0,0,1,1, 1,32'h100,0,32'h0,  0};
        tbl[14] = '{0,0,0,1,1, 1,32'h104,0,32'h0,  0};
        tbl[15] = '{0,0,0,1,1, 1,32'h108,1,32'h100,1};

        // First cycle: state is undefined before the reset edge.
        apply(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();

        for (int i = 0; i < 16; i++) begin
            apply(tbl[i].r, tbl[i].rd, tbl[i].rp, tbl[i].rdy, tbl[i].idr, 1'b1);
            chk("tbl_req_valid", 32'(imem_req_valid), 32'(tbl[i].e_req));
            if (!tbl[i].r) begin
                chk("tbl_req_addr", imem_req_addr, tbl[i].e_addr);
                chk("tbl_id_valid", 32'(id_valid), 32'(tbl[i].e_idv));
                chk("tbl_occupancy", 32'(occupancy), 32'(tbl[i].e_occ));
                if (tbl[i].e_idv || tbl[i].e_occ == 0)
                    chk("tbl_id_pc", id_pc, tbl[i].e_pc);
            end
            $display("vec %0d: req=%0b addr=%h id_valid=%0b id_pc=%h occ=%0d",
                     i, imem_req_valid, imem_req_addr, id_valid, id_pc, occupancy);
            tick();
        end

        // Latency 3, two outstanding max: steady state is 2 requests per 4 cycles.
        do_reset();
        lat_lo = 3; lat_hi = 3;
        for (int k = 0; k < 8; k++) begin apply(0, 0, 0, 1, 1, 1); tick(); end
        fires = 0;
        for (int k = 0; k < 12; k++) begin
            apply(0, 0, 0, 1, 1, 1);
            if (dut_fire) fires++;
            tick();
        end
        chk("throughput_12cyc", 32'(fires), 32'd6);
        $display("seq throughput: %0d requests in 12 cycles", fires);

        // Redirect with two requests outstanding and no response this cycle.
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (mem_q.size() == 2 && !rsp_due()) found = 1;
            else begin apply(0, 0, 0, 1, 1, 1); tick(); end
        end
        chk("redir2_setup", 32'(found), 32'd1);
        apply(0, 1, 32'h100, 1, 1, 1);
        tick();
        apply(0, 0, 0, 1, 1, 1);
        chk("redir2_occ_after", 32'(occupancy), 32'd0);
        tick();
        found = 0; first_pc = 32'hDEAD_BEEF;
        for (int k = 0; k < 30 && !found; k++) begin
            apply(0, 0, 0, 1, 1, 1);
            if (id_valid) begin found = 1; first_pc = id_pc; end
            tick();
        end
        chk("redir2_first_pc", first_pc, 32'h100);
        $display("seq redirect-2-inflight: first id_pc=%h", first_pc);

        // Redirect in the same cycle as a response and a pop request.
        do_reset();
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (mem_q.size() == 2 && rsp_due() && fifo_m.size() > 0) found = 1;
            else begin apply(0, 0, 0, 1, 0, 1); tick(); end
        end
        chk("redir_rsp_setup", 32'(found), 32'd1);
        apply(0, 1, 32'h200, 1, 1, 1);
        chk("redir_rsp_id_valid", 32'(id_valid), 32'd0);
        chk("redir_rsp_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        apply(0, 0, 0, 1, 1, 1);
        chk("redir_rsp_occ_after", 32'(occupancy), 32'd0);
        tick();
        found = 0; first_pc = 32'hDEAD_BEEF;
        for (int k = 0; k < 30 && !found; k++) begin
            apply(0, 0, 0, 1, 1, 1);
            if (id_valid) begin found = 1; first_pc = id_pc; end
            tick();
        end
        chk("redir_rsp_first_pc", first_pc, 32'h200);
        $display("seq redirect-with-rsp: first id_pc=%h", first_pc);

        // Reset with a full FIFO.
        lat_lo = 1; lat_hi = 1;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (fifo_m.size() == DEPTH) found = 1;
            else begin apply(0, 0, 0, 1, 0, 1); tick(); end
        end
        chk("full_setup", 32'(found), 32'd1);
        chk("full_occ", 32'(occupancy), 32'(DEPTH));
        do_reset();
        apply(0, 0, 0, 1, 0, 1);
        chk("rst_full_id_valid", 32'(id_valid), 32'd0);
        chk("rst_full_id_ir", id_ir, NOOP);
        chk("rst_full_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rst_full_req_addr", imem_req_addr, RESET_PC);
        tick();
        $display("seq reset-when-full: done");

        // Randomised traffic against the model.
        rsp_pct = 70; lat_lo = 1; lat_hi = 4;
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] rp;
            rp = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            apply(($urandom_range(199) == 0), ($urandom_range(19) == 0), rp,
                  ($urandom_range(3) != 0), ($urandom_range(2) != 0), 1'b1);
            tick();
        end
        $display("seq random: 3000 cycles");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
